// File: rtl/food_spawner_if.sv
// Signal bundle between food_spawner and its surroundings (random source, body RAM, renderer).
// The master drives the request/random/RAM-data side; the slave is the spawner itself.
interface food_spawner_if #(
  parameter int unsigned LEN_W = 8
) ();
  logic [9:0]       rand_x;
  logic [8:0]       rand_y;
  logic             spawn_req;
  logic [LEN_W-1:0] snake_len;
  logic [LEN_W-1:0] body_addr;
  logic [5:0]       body_col;
  logic [5:0]       body_row;
  logic [9:0]       food_x;
  logic [8:0]       food_y;
  logic             food_valid;
  logic             busy;
  logic             spawn_done;
  logic             spawn_fail;

  modport master (
    output rand_x, rand_y, spawn_req, snake_len, body_col, body_row,
    input  body_addr, food_x, food_y, food_valid, busy, spawn_done, spawn_fail
  );

  modport slave (
    input  rand_x, rand_y, spawn_req, snake_len, body_col, body_row,
    output body_addr, food_x, food_y, food_valid, busy, spawn_done, spawn_fail
  );
endinterface

// File: rtl/food_spawner.sv
// Picks a free grid cell from the random stream, rejecting cells covered by the snake body.
// Define FOOD_BORDER_EXCL_EN to also reject wall cells on the grid border.
module food_spawner #(
  parameter int unsigned GRID_W    = 64,
  parameter int unsigned GRID_H    = 48,
  parameter int unsigned CELL_SIZE = 10,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  food_spawner_if.slave bus
);

  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {StIdle, StSample, StRead, StCmp, StPlace} state_e;

  state_e           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] r_body_addr, w_body_addr_nxt;
  logic [TryW-1:0]  r_tries, w_tries_nxt;
  logic [5:0]       r_col, w_col_nxt;
  logic [5:0]       r_row, w_row_nxt;
  logic             r_fail_flag, w_fail_flag_nxt;
  logic [9:0]       r_food_x, w_food_x_nxt;
  logic [8:0]       r_food_y, w_food_y_nxt;
  logic             r_food_valid, w_food_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_spawn_done, w_spawn_done_nxt;
  logic             r_spawn_fail, w_spawn_fail_nxt;

  logic [5:0]       w_cand_col;
  logic [5:0]       w_row_raw;
  logic [5:0]       w_cand_row;
  logic             w_hit;
  logic             w_unused_rand;

  assign w_cand_col = bus.rand_x[5:0] & 6'(GRID_W - 1);
  assign w_row_raw  = bus.rand_y[5:0];
  // Fold 48..63 back onto 0..15 instead of resampling.
  assign w_cand_row = ({1'b0, w_row_raw} >= 7'(GRID_H)) ? (w_row_raw - 6'(GRID_H)) : w_row_raw;
  assign w_hit      = (bus.body_col == r_col) && (bus.body_row == r_row);
  assign w_unused_rand = ^{bus.rand_x[9:6], bus.rand_y[8:6]};

`ifdef FOOD_BORDER_EXCL_EN
  logic w_border;
  assign w_border = (w_cand_col == 6'd0) || (w_cand_col == 6'(GRID_W - 1)) ||
                    (w_cand_row == 6'd0) || (w_cand_row == 6'(GRID_H - 1));
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_body_addr_nxt  = r_body_addr;
    w_tries_nxt      = r_tries;
    w_col_nxt        = r_col;
    w_row_nxt        = r_row;
    w_fail_flag_nxt  = r_fail_flag;
    w_food_x_nxt     = r_food_x;
    w_food_y_nxt     = r_food_y;
    w_food_valid_nxt = r_food_valid;
    w_busy_nxt       = r_busy;
    w_spawn_done_nxt = 1'b0;
    w_spawn_fail_nxt = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.spawn_req) begin
          w_len_nxt       = bus.snake_len;
          w_tries_nxt     = '0;
          w_fail_flag_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = StSample;
        end
      end
      StSample: begin
        w_tries_nxt = r_tries + TryW'(1);
        w_col_nxt   = w_cand_col;
        w_row_nxt   = w_cand_row;
        if (r_len == '0) begin
          w_state_nxt = StPlace;
        end else begin
          w_body_addr_nxt = '0;
          w_state_nxt     = StRead;
        end
`ifdef FOOD_BORDER_EXCL_EN
        if (w_border) begin
          w_body_addr_nxt = r_body_addr;
          if (w_tries_nxt == TryW'(MAX_TRIES)) begin
            w_fail_flag_nxt = 1'b1;
            w_state_nxt     = StPlace;
          end else begin
            w_state_nxt = StSample;
          end
        end
`endif
      end
      StRead: begin
        w_state_nxt = StCmp;
      end
      StCmp: begin
        if (w_hit) begin
          if (r_tries == TryW'(MAX_TRIES)) begin
            w_fail_flag_nxt = 1'b1;
            w_state_nxt     = StPlace;
          end else begin
            w_state_nxt = StSample;
          end
        end else if (r_body_addr == r_len - LEN_W'(1)) begin
          w_state_nxt = StPlace;
        end else begin
          w_body_addr_nxt = r_body_addr + LEN_W'(1);
          w_state_nxt     = StRead;
        end
      end
      StPlace: begin
        w_state_nxt      = StIdle;
        w_busy_nxt       = 1'b0;
        w_spawn_done_nxt = 1'b1;
        if (r_fail_flag) begin
          w_spawn_fail_nxt = 1'b1;
        end else begin
          w_food_x_nxt     = 10'(r_col * CELL_SIZE);
          w_food_y_nxt     = 9'(r_row * CELL_SIZE);
          w_food_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_len        <= '0;
      r_body_addr  <= '0;
      r_tries      <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_fail_flag  <= 1'b0;
      r_food_x     <= '0;
      r_food_y     <= '0;
      r_food_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_spawn_done <= 1'b0;
      r_spawn_fail <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_body_addr  <= w_body_addr_nxt;
      r_tries      <= w_tries_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_fail_flag  <= w_fail_flag_nxt;
      r_food_x     <= w_food_x_nxt;
      r_food_y     <= w_food_y_nxt;
      r_food_valid <= w_food_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_spawn_done <= w_spawn_done_nxt;
      r_spawn_fail <= w_spawn_fail_nxt;
    end
  end

  assign bus.body_addr  = r_body_addr;
  assign bus.food_x     = r_food_x;
  assign bus.food_y     = r_food_y;
  assign bus.food_valid = r_food_valid;
  assign bus.busy       = r_busy;
  assign bus.spawn_done = r_spawn_done;
  assign bus.spawn_fail = r_spawn_fail;

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: reset, placement math, body rejection, give-up path,
// request while busy and reset mid-scan.
module tb_food_spawner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  food_spawner_if #(.LEN_W(8)) bus ();

  food_spawner #(
    .GRID_W   (64),
    .GRID_H   (48),
    .CELL_SIZE(10),
    .LEN_W    (8),
    .MAX_TRIES(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // Body RAM model: one-cycle registered read.
  logic [5:0] mem_col [256];
  logic [5:0] mem_row [256];
  always @(posedge clk) begin
    bus.body_col <= mem_col[bus.body_addr];
    bus.body_row <= mem_row[bus.body_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse spawn_req in cycle 0; switch rand to (x1,y1) at cycle sw; re-pulse spawn_req at pc.
  task automatic spawn(input logic [9:0] x0, input logic [8:0] y0,
                       input logic [9:0] x1, input logic [8:0] y1,
                       input int sw, input int pc,
                       output int done_cyc, output logic fail, output logic busy_at_done);
    bus.rand_x    = x0;
    bus.rand_y    = y0;
    bus.spawn_req = 1'b1;
    done_cyc      = -1;
    fail          = 1'b0;
    busy_at_done  = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      bus.spawn_req = (c == pc);
      if (c == sw) begin
        bus.rand_x = x1;
        bus.rand_y = y1;
      end
      if (bus.spawn_done) begin
        done_cyc     = c;
        fail         = bus.spawn_fail;
        busy_at_done = bus.busy;
        break;
      end
    end
    bus.spawn_req = 1'b0;
  endtask

  int   dc;
  logic fl;
  logic bz;
  int   extra;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_col[i] = 6'd63;
      mem_row[i] = 6'd63;
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rand_x    = 10'($urandom);
      bus.rand_y    = 9'($urandom);
      bus.spawn_req = 1'($urandom);
      bus.snake_len = 8'($urandom);
      tick();
    end
    check_eq("rst_food_x", 32'(bus.food_x), 0);
    check_eq("rst_food_y", 32'(bus.food_y), 0);
    check_eq("rst_valid", 32'(bus.food_valid), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_done", 32'(bus.spawn_done), 0);
    check_eq("rst_fail", 32'(bus.spawn_fail), 0);
    check_eq("rst_addr", 32'(bus.body_addr), 0);
    rst           = 1'b0;
    bus.spawn_req = 1'b0;
    bus.snake_len = 8'd0;
    tick();

    // Empty snake, direct placement.
    spawn(10'd37, 9'd20, 10'd37, 9'd20, 0, 0, dc, fl, bz);
    check_eq("len0_done_cyc", 32'(dc), 3);
    check_eq("len0_fail", 32'(fl), 0);
    check_eq("len0_busy", 32'(bz), 0);
    check_eq("len0_x", 32'(bus.food_x), 370);
    check_eq("len0_y", 32'(bus.food_y), 200);
    check_eq("len0_valid", 32'(bus.food_valid), 1);
    tick();
    check_eq("len0_done_pulse", 32'(bus.spawn_done), 0);

    // Column masking and row fold: (70,53) -> col 6, row 5.
    spawn(10'd70, 9'd53, 10'd70, 9'd53, 0, 0, dc, fl, bz);
    check_eq("fold_done_cyc", 32'(dc), 3);
    check_eq("fold_x", 32'(bus.food_x), 60);
    check_eq("fold_y", 32'(bus.food_y), 50);
    tick();

    // One retry against a 3-entry body.
    mem_col[0] = 6'd5; mem_row[0] = 6'd5;
    mem_col[1] = 6'd6; mem_row[1] = 6'd5;
    mem_col[2] = 6'd7; mem_row[2] = 6'd5;
    bus.snake_len = 8'd3;
    spawn(10'd6, 9'd5, 10'd20, 9'd10, 6, 0, dc, fl, bz);
    check_eq("retry_done_cyc", 32'(dc), 14);
    check_eq("retry_fail", 32'(fl), 0);
    check_eq("retry_x", 32'(bus.food_x), 200);
    check_eq("retry_y", 32'(bus.food_y), 100);
    tick();

    // Every candidate hits entry 0: gives up after 4 tries, food kept.
    mem_col[0]    = 6'd9; mem_row[0] = 6'd9;
    bus.snake_len = 8'd1;
    spawn(10'd9, 9'd9, 10'd9, 9'd9, 0, 0, dc, fl, bz);
    check_eq("giveup_done_cyc", 32'(dc), 14);
    check_eq("giveup_fail", 32'(fl), 1);
    check_eq("giveup_busy", 32'(bz), 0);
    check_eq("giveup_x", 32'(bus.food_x), 200);
    check_eq("giveup_y", 32'(bus.food_y), 100);
    check_eq("giveup_valid", 32'(bus.food_valid), 1);
    tick();
    check_eq("giveup_fail_pulse", 32'(bus.spawn_fail), 0);

    // Request during READ is ignored.
    mem_col[0]    = 6'd5; mem_row[0] = 6'd5;
    bus.snake_len = 8'd3;
    spawn(10'd30, 9'd30, 10'd30, 9'd30, 0, 2, dc, fl, bz);
    check_eq("busyreq_done_cyc", 32'(dc), 9);
    check_eq("busyreq_x", 32'(bus.food_x), 300);
    check_eq("busyreq_y", 32'(bus.food_y), 300);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.spawn_done || bus.busy) extra++;
    end
    check_eq("busyreq_no_second", 32'(extra), 0);

    // Reset during CMP (cycle 3).
    bus.rand_x    = 10'd40;
    bus.rand_y    = 9'd40;
    bus.spawn_req = 1'b1;
    tick();
    bus.spawn_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_busy", 32'(bus.busy), 0);
    check_eq("midrst_valid", 32'(bus.food_valid), 0);
    check_eq("midrst_x", 32'(bus.food_x), 0);
    check_eq("midrst_addr", 32'(bus.body_addr), 0);
    rst           = 1'b0;
    bus.snake_len = 8'd0;
    spawn(10'd45, 9'd12, 10'd45, 9'd12, 0, 0, dc, fl, bz);
    check_eq("postrst_done_cyc", 32'(dc), 3);
    check_eq("postrst_x", 32'(bus.food_x), 450);
    check_eq("postrst_y", 32'(bus.food_y), 120);
    check_eq("postrst_valid", 32'(bus.food_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
